// File: rtl/xm_pkg.sv
// Shared definitions for the register context save/restore engine.
// Contents: data word width, byte width, and the engine state encoding.
package xm_pkg;

  localparam int unsigned WORD = 16;
  localparam int unsigned BYTE = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SV_RD = 3'd1,
    ST_SV_WR = 3'd2,
    ST_RS_RD = 3'd3,
    ST_RS_WR = 3'd4,
    ST_DONE  = 3'd5
  } ctx_state_e;

endpackage

// File: rtl/reg_context_engine_if.sv
// Bus bundle between the context engine and its neighbours.
// Groups the command inputs, status outputs, register-file read/write ports
// and the memory request bus.
// Modport master is the engine side; modport slave is the control unit,
// register file and memory side.
interface reg_context_engine_if #(
  parameter int unsigned WORD      = xm_pkg::WORD,
  parameter int unsigned REGISTERS = 8
);

  localparam int unsigned IDX_W = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
  localparam int unsigned BYTES = WORD / xm_pkg::BYTE;

  logic             save_i;
  logic             restore_i;
  logic [WORD-1:0]  base_i;
  logic             busy_o;
  logic             done_o;
  logic [IDX_W-1:0] rfRdAddr_o;
  logic [WORD-1:0]  rfData_i;
  logic             rfWrEn_o;
  logic [BYTES-1:0] rfWrMode_o;
  logic [IDX_W-1:0] rfWrAddr_o;
  logic [WORD-1:0]  rfData_o;
  logic             memReq_o;
  logic             memWr_o;
  logic [WORD-1:0]  memAddr_o;
  logic [WORD-1:0]  memData_o;
  logic [WORD-1:0]  memData_i;
  logic             memAck_i;

  modport master (
    input  save_i, restore_i, base_i, rfData_i, memData_i, memAck_i,
    output busy_o, done_o, rfRdAddr_o, rfWrEn_o, rfWrMode_o, rfWrAddr_o,
           rfData_o, memReq_o, memWr_o, memAddr_o, memData_o
  );

  modport slave (
    output save_i, restore_i, base_i, rfData_i, memData_i, memAck_i,
    input  busy_o, done_o, rfRdAddr_o, rfWrEn_o, rfWrMode_o, rfWrAddr_o,
           rfData_o, memReq_o, memWr_o, memAddr_o, memData_o
  );

endinterface

// File: rtl/reg_context_engine.sv
// Register context save/restore engine.
// Streams R0..R[REGISTERS-1] to memory starting at a byte base address
// (save), or loads them all back from memory (restore).
// Ports: clk_i (rising-edge clock), arst_i (async active-high reset),
//        bus (master side: commands/status, register-file ports, memory bus).
module reg_context_engine #(
  parameter int unsigned WORD      = xm_pkg::WORD,
  parameter int unsigned REGISTERS = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  reg_context_engine_if.master bus
);

  import xm_pkg::*;

  localparam int unsigned IDX_W = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
  localparam int unsigned BYTES = WORD / BYTE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REGISTERS - 1);
  localparam logic [WORD-1:0]  STRIDE   = WORD'(BYTES);

  ctx_state_e       state;
  ctx_state_e       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WORD-1:0]  addr;
  logic [WORD-1:0]  wr_data;
  logic [WORD-1:0]  rd_data;
  logic             last;
  logic             start;
  logic             advance;

  assign last  = (idx == LAST_IDX);
  assign start = bus.save_i | bus.restore_i;

  // Move to the next register after a completed write of either direction.
  assign advance = !last && (((state == ST_SV_WR) && bus.memAck_i) || (state == ST_RS_WR));

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; save has priority over restore
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.save_i)         state_nxt = ST_SV_RD;
        else if (bus.restore_i) state_nxt = ST_RS_RD;
      end
      ST_SV_RD: state_nxt = ST_SV_WR;
      ST_SV_WR: if (bus.memAck_i) state_nxt = last ? ST_DONE : ST_SV_RD;
      ST_RS_RD: if (bus.memAck_i) state_nxt = ST_RS_WR;
      ST_RS_WR: state_nxt = last ? ST_DONE : ST_RS_RD;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    bus.busy_o     = 1'b0;
    bus.done_o     = 1'b0;
    bus.rfWrEn_o   = 1'b0;
    bus.rfWrMode_o = '0;
    bus.memReq_o   = 1'b0;
    bus.memWr_o    = 1'b0;
    case (state)
      ST_IDLE:  ;
      ST_SV_RD: bus.busy_o = 1'b1;
      ST_SV_WR: begin
        bus.busy_o   = 1'b1;
        bus.memReq_o = 1'b1;
        bus.memWr_o  = 1'b1;
      end
      ST_RS_RD: begin
        bus.busy_o   = 1'b1;
        bus.memReq_o = 1'b1;
      end
      ST_RS_WR: begin
        bus.busy_o     = 1'b1;
        bus.rfWrEn_o   = 1'b1;
        bus.rfWrMode_o = '1;
      end
      ST_DONE: begin
        bus.busy_o = 1'b1;
        bus.done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Index, running address and data capture registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      idx     <= '0;
      addr    <= '0;
      wr_data <= '0;
      rd_data <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        idx  <= '0;
        addr <= bus.base_i;
      end else if (advance) begin
        idx  <= idx + IDX_W'(1);
        // Wraps modulo 2^WORD by construction
        addr <= addr + STRIDE;
      end
      if (state == ST_SV_RD) wr_data <= bus.rfData_i;
      if ((state == ST_RS_RD) && bus.memAck_i) rd_data <= bus.memData_i;
    end
  end

  assign bus.rfRdAddr_o = idx;
  assign bus.rfWrAddr_o = idx;
  assign bus.rfData_o   = rd_data;
  assign bus.memAddr_o  = addr;
  assign bus.memData_o  = wr_data;

endmodule

// File: tb/tb_reg_context_engine.sv
// Directed self-checking bench for reg_context_engine with a register-file
// model and a memory model supporting constant ack or fixed wait states.
module tb_reg_context_engine;

  localparam int unsigned WORD = 16;
  localparam int unsigned REGS = 8;
  localparam int BUDGET = 400;

  logic clk = 1'b0;
  logic arst;

  reg_context_engine_if #(.WORD(WORD), .REGISTERS(REGS)) bus ();

  reg_context_engine #(.WORD(WORD), .REGISTERS(REGS)) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [8];
  logic [15:0] mem [65536];
  int errors = 0;
  int checks = 0;

  bit ack_const = 1'b0;
  int wait_states = 0;
  int wcnt = 0;
  logic ack_r = 1'b0;
  logic [15:0] rd_r = 16'h0;
  logic [15:0] wa [$];
  logic [15:0] wd [$];
  int nrd, nrfw, mode_bad;

  assign bus.rfData_i  = regs[bus.rfRdAddr_o];
  assign bus.memAck_i  = ack_r;
  assign bus.memData_i = rd_r;

  // Memory responder: ack either every cycle or after wait_states request cycles
  always @(negedge clk) begin
    if (ack_const) begin
      ack_r = 1'b1;
      rd_r  = mem[bus.memAddr_o];
    end else if (bus.memReq_o === 1'b1) begin
      if (wcnt >= wait_states) begin
        ack_r = 1'b1;
        rd_r  = mem[bus.memAddr_o];
        wcnt  = 0;
      end else begin
        ack_r = 1'b0;
        wcnt++;
      end
    end else begin
      ack_r = 1'b0;
      wcnt  = 0;
    end
  end

  // Transaction monitor, memory write-back and register-file write port
  always @(posedge clk) begin
    if (bus.memReq_o === 1'b1 && bus.memAck_i === 1'b1) begin
      if (bus.memWr_o === 1'b1) begin
        mem[bus.memAddr_o] = bus.memData_o;
        wa.push_back(bus.memAddr_o);
        wd.push_back(bus.memData_o);
      end else begin
        nrd++;
      end
    end
    if (bus.rfWrEn_o === 1'b1) begin
      nrfw++;
      if (bus.rfWrMode_o !== 2'b11) mode_bad++;
      regs[bus.rfWrAddr_o] = bus.rfData_o;
    end
  end

  task automatic clear_logs();
    wa.delete();
    wd.delete();
    nrd = 0;
    nrfw = 0;
    mode_bad = 0;
  endtask

  // Issue a command; report the cycle of done_o (cycle 1 = first cycle after the sampling edge)
  task automatic run_cmd(input bit sv, input bit rs, input logic [15:0] b, input int inject,
                         output int done_cyc, output int done_cnt, output int busy_low,
                         output logic post_busy);
    done_cyc = 0;
    done_cnt = 0;
    busy_low = 0;
    post_busy = 1'bx;
    @(negedge clk);
    bus.save_i = sv;
    bus.restore_i = rs;
    bus.base_i = b;
    @(posedge clk);
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      bus.save_i = 1'b0;
      bus.restore_i = (c == inject);
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (done_cyc == 0 && bus.busy_o !== 1'b1) busy_low++;
      if (done_cyc != 0 && c == done_cyc + 1) post_busy = bus.busy_o;
      if (done_cyc != 0 && c >= done_cyc + 3) break;
    end
    bus.restore_i = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    #12;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    checks++; if (bus.memReq_o !== 1'b0 || bus.memWr_o !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl: got req=%b wr=%b want 0/0", bus.memReq_o, bus.memWr_o); end
    checks++; if (bus.rfWrEn_o !== 1'b0 || bus.rfWrMode_o !== 2'b00) begin errors++; $display("FAIL reset_rf_ctl: got en=%b mode=%b want 0/00", bus.rfWrEn_o, bus.rfWrMode_o); end
    checks++; if (bus.memAddr_o !== 16'h0 || bus.memData_o !== 16'h0 || bus.rfData_o !== 16'h0) begin errors++; $display("FAIL reset_data: got addr=%h mdata=%h rfdata=%h want 0", bus.memAddr_o, bus.memData_o, bus.rfData_o); end
    checks++; if (bus.rfRdAddr_o !== 3'd0 || bus.rfWrAddr_o !== 3'd0) begin errors++; $display("FAIL reset_rf_addr: got rd=%0d wr=%0d want 0", bus.rfRdAddr_o, bus.rfWrAddr_o); end
    @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_save_zero_wait();
    int dc, dn, bl;
    logic pb;
    for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
    clear_logs();
    ack_const = 1'b1;
    run_cmd(1'b1, 1'b0, 16'h0200, 0, dc, dn, bl, pb);
    checks++; if (dc != 17) begin errors++; $display("FAIL save_done_cycle: got %0d want 17", dc); end
    checks++; if (dn != 1) begin errors++; $display("FAIL save_done_count: got %0d want 1", dn); end
    checks++; if (bl != 0) begin errors++; $display("FAIL save_busy: low for %0d cycles want 0", bl); end
    checks++; if (pb !== 1'b0) begin errors++; $display("FAIL save_busy_after: got %b want 0", pb); end
    checks++; if (wa.size() != 8) begin errors++; $display("FAIL save_nwrites: got %0d want 8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== 16'h0200 + 16'(2 * i) || wd[i] !== 16'h1000 + 16'(i)) begin
        errors++;
        $display("FAIL save_write%0d: got %h<=%h want %h<=%h", i, wa[i], wd[i], 16'h0200 + 16'(2 * i), 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_restore_wait();
    int dc, dn, bl;
    logic pb;
    for (int i = 0; i < 8; i++) begin
      regs[i] = 16'h0000;
      mem[16'h0400 + 16'(2 * i)] = 16'hA000 + 16'(i);
    end
    clear_logs();
    ack_const = 1'b0;
    wait_states = 2;
    run_cmd(1'b0, 1'b1, 16'h0400, 0, dc, dn, bl, pb);
    checks++; if (dc != 33) begin errors++; $display("FAIL restore_done_cycle: got %0d want 33", dc); end
    checks++; if (bl != 0) begin errors++; $display("FAIL restore_busy: low for %0d cycles want 0", bl); end
    checks++; if (mode_bad != 0) begin errors++; $display("FAIL restore_wrmode: %0d writes without mode 11, want 0", mode_bad); end
    checks++; if (nrfw != 8 || nrd != 8 || wa.size() != 0) begin errors++; $display("FAIL restore_counts: got rfw=%0d rd=%0d memwr=%0d want 8/8/0", nrfw, nrd, wa.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (regs[i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL restore_r%0d: got %h want %h", i, regs[i], 16'hA000 + 16'(i)); end
    end
  endtask

  task automatic test_simultaneous();
    int dc, dn, bl;
    logic pb;
    clear_logs();
    ack_const = 1'b1;
    run_cmd(1'b1, 1'b1, 16'h0300, 0, dc, dn, bl, pb);
    checks++; if (wa.size() != 8 || nrd != 0 || nrfw != 0) begin errors++; $display("FAIL simul_save_wins: got memwr=%0d rd=%0d rfw=%0d want 8/0/0", wa.size(), nrd, nrfw); end
    checks++; if (dc != 17) begin errors++; $display("FAIL simul_done_cycle: got %0d want 17", dc); end
  endtask

  task automatic test_cmd_while_busy();
    int dc, dn, bl;
    logic pb;
    clear_logs();
    ack_const = 1'b1;
    run_cmd(1'b1, 1'b0, 16'h0100, 5, dc, dn, bl, pb);
    checks++; if (wa.size() != 8 || nrd != 0 || nrfw != 0) begin errors++; $display("FAIL busy_ignore: got memwr=%0d rd=%0d rfw=%0d want 8/0/0", wa.size(), nrd, nrfw); end
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", dn); end
    checks++; if (pb !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b want 0", pb); end
  endtask

  task automatic test_addr_wrap();
    int dc, dn, bl;
    logic pb;
    logic [15:0] exp_a [8];
    exp_a = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A};
    clear_logs();
    ack_const = 1'b1;
    run_cmd(1'b1, 1'b0, 16'hFFFC, 0, dc, dn, bl, pb);
    checks++; if (wa.size() != 8) begin errors++; $display("FAIL wrap_nwrites: got %0d want 8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, wa[i], exp_a[i]); end
    end
  endtask

  task automatic test_reset_mid_restore();
    int dc, dn, bl;
    logic pb;
    bit hit;
    for (int i = 0; i < 8; i++) begin
      regs[i] = 16'h5500 + 16'(i);
      mem[16'h0600 + 16'(2 * i)] = 16'hB000 + 16'(i);
    end
    clear_logs();
    ack_const = 1'b0;
    wait_states = 1;
    hit = 1'b0;
    @(negedge clk);
    bus.restore_i = 1'b1;
    bus.base_i = 16'h0600;
    @(posedge clk);
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      bus.restore_i = 1'b0;
      // Reset lands while R3's write is being presented
      if (bus.rfWrEn_o === 1'b1 && bus.rfWrAddr_o === 3'd3) begin
        arst = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach: got no R3 write in %0d cycles want one", BUDGET); end
    #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.rfWrEn_o !== 1'b0 || bus.memReq_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl: got busy=%b rfwe=%b req=%b want 0", bus.busy_o, bus.rfWrEn_o, bus.memReq_o); end
    checks++; if (bus.memAddr_o !== 16'h0 || bus.rfData_o !== 16'h0 || bus.rfWrMode_o !== 2'b00) begin errors++; $display("FAIL rst_mid_data: got addr=%h rfdata=%h mode=%b want 0", bus.memAddr_o, bus.rfData_o, bus.rfWrMode_o); end
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    checks++; if (nrfw != 3) begin errors++; $display("FAIL rst_mid_nwrites: got %0d want 3", nrfw); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (regs[i] !== ((i < 3) ? 16'hB000 + 16'(i) : 16'h5500 + 16'(i))) begin
        errors++;
        $display("FAIL rst_mid_r%0d: got %h want %h", i, regs[i], (i < 3) ? 16'hB000 + 16'(i) : 16'h5500 + 16'(i));
      end
    end
    clear_logs();
    ack_const = 1'b1;
    run_cmd(1'b1, 1'b0, 16'h0800, 0, dc, dn, bl, pb);
    checks++; if (dc != 17) begin errors++; $display("FAIL rst_then_save_done: got %0d want 17", dc); end
    checks++; if (wa.size() != 8) begin errors++; $display("FAIL rst_then_save_nwrites: got %0d want 8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== 16'h0800 + 16'(2 * i) || wd[i] !== ((i < 3) ? 16'hB000 + 16'(i) : 16'h5500 + 16'(i))) begin
        errors++;
        $display("FAIL rst_then_save%0d: got %h<=%h", i, wa[i], wd[i]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    bus.save_i = 1'b0;
    bus.restore_i = 1'b0;
    bus.base_i = 16'h0000;
    clear_logs();
    test_reset();
    test_save_zero_wait();
    test_restore_wait();
    test_simultaneous();
    test_cmd_while_busy();
    test_addr_wrap();
    test_reset_mid_restore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_context_engine.md
# reg_context_engine

Save/restore engine for the register file: on command it streams every register (R0..R[REGISTERS-1]) out to data memory at a base address, or loads them all back from memory. It sits between the control unit, the register file's write/read ports and the memory bus. It is the consumer of the register file's read port and the producer of its write port, used for exception entry/exit and context switches.

## Interface
- `WORD`, 16, register and memory data width in bits (multiple of 8)
- `REGISTERS`, 8, number of registers transferred
- `clk_i`  in  1  clock; all state updates on rising edge
- `arst_i`  in  1  asynchronous active-high reset
- `save_i`  in  1  start a save (registers -> memory); sampled in IDLE only
- `restore_i`  in  1  start a restore (memory -> registers); sampled in IDLE only
- `base_i`  in  WORD  byte base address; captured with the command
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  one-cycle pulse when a transfer completes
- `rfRdAddr_o`  out  $clog2(REGISTERS)  register file read address
- `rfData_i`  in  WORD  register file read data (asynchronous read of `rfRdAddr_o`)
- `rfWrEn_o`  out  1  register file write enable
- `rfWrMode_o`  out  WORD/8  byte write mask; all ones when `rfWrEn_o` is high, else 0
- `rfWrAddr_o`  out  $clog2(REGISTERS)  register file write address
- `rfData_o`  out  WORD  register file write data
- `memReq_o`  out  1  memory request
- `memWr_o`  out  1  1 = write, 0 = read; valid while `memReq_o` is high
- `memAddr_o`  out  WORD  byte address
- `memData_o`  out  WORD  memory write data
- `memData_i`  in  WORD  memory read data; valid in the `memAck_i` cycle
- `memAck_i`  in  1  request accepted/complete; ignored unless `memReq_o` is high

## Operation
- States: IDLE, SV_RD, SV_WR, RS_RD, RS_WR, DONE.
- IDLE:
  - `save_i` -> SV_RD, otherwise `restore_i` -> RS_RD.
  - On either command: index k=0 and base captured.
  - Both high together: save wins. Commands outside IDLE are ignored.
- SV_RD (1 cycle):
  - `rfRdAddr_o`=k.
  - `rfData_i` is captured into the `memData_o` register.
  - Next state is SV_WR.
- SV_WR:
  - `memReq_o`=1, `memWr_o`=1, `memAddr_o`=base+k*(WORD/8).
  - Outputs are held stable until `memAck_i`.
  - On ack: if k=REGISTERS-1 -> DONE, else k+1 -> SV_RD.
- RS_RD:
  - `memReq_o`=1, `memWr_o`=0, same address formula.
  - On `memAck_i`, `memData_i` is captured into `rfData_o` and the state moves to RS_WR.
- RS_WR (1 cycle):
  - `rfWrEn_o`=1, `rfWrMode_o`=all ones, `rfWrAddr_o`=k.
  - If k=REGISTERS-1 -> DONE, else k+1 -> RS_RD.
- DONE (1 cycle): `done_o`=1, then back to IDLE.
- Address arithmetic is WORD bits wide and wraps modulo 2^WORD; no overflow is flagged.
- The PC register is transferred like any other register. The block never drives the register file's PC-update port.

## Timing
- Reset values:
  - State IDLE, k=0.
  - `busy_o`, `done_o`, `rfWrEn_o`, `rfWrMode_o`, `memReq_o`, `memWr_o` = 0.
  - All address and data outputs = 0.
- Command is sampled at edge n; `busy_o` is high from n+1.
- Save, per register: 1 cycle SV_RD + (1 + wait) cycles SV_WR. With zero-wait ack, a full save takes 2*REGISTERS cycles, then DONE.
- Restore, per register: (1 + wait) cycles RS_RD + 1 cycle RS_WR; same zero-wait total.
- `memAck_i` may be asserted in the first request cycle.
- `memReq_o` never drops while an ack is still outstanding.
- Reset asserted mid-transfer:
  - Immediate return to IDLE; all outputs go to their reset values asynchronously.
  - No partial register write occurs after reset.
  - Registers already written stay written.
- `memAck_i` while `memReq_o`=0 has no effect.

## Structure
- Shared package `xm_pkg`:
  - state enum `ctx_state_e`
  - `WORD` and `BYTE` constants
- Single module; no sub-module is warranted. The address incrementer is inline.

## Test plan
- Save zero-wait: R0..R7 preloaded 0x1000+i, `base_i`=0x0200, constant ack.
  - Memory receives writes 0x0200..0x020E with data 0x1000..0x1007.
  - `done_o` pulses at cycle 17 after the command.
- Restore with wait states: memory holds 0xA000+i at 0x0400+2i, ack delayed 2 cycles.
  - R0..R7 end as 0xA000..0xA007.
  - `rfWrMode_o`=2'b11 on each write; `busy_o` stays high throughout.
- Simultaneous `save_i` and `restore_i` in IDLE: only memory writes occur (save wins).
- Save while busy: a restore pulse mid-save is ignored; exactly 8 memory writes, one `done_o`.
- Address wrap: `base_i`=0xFFFC.
  - Addresses 0xFFFC, 0xFFFE, 0x0000 … 0x000A.
- Reset during restore after 3 registers:
  - Outputs go to 0 at once; R0..R2 updated, R3..R7 unchanged.
  - A new save command then runs normally.
